// File: rtl/fsm_1100_pkg.sv
// Shared types and constants for the serial 1100 pattern detector.
package fsm_1100_pkg;

  // Each state records the longest prefix of 1100 seen so far.
  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  localparam logic [3:0] PATTERN = 4'b1100;

endpackage

// File: rtl/fsm_1100_detector.sv
// Moore-style serial detector: one-cycle registered pulse after 1-1-0-0 is sampled.
// state_dbg_o exposes the current state for observation and checkers.
module fsm_1100_detector
  import fsm_1100_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_in,
  output logic       pattern_detected,
  output logic [1:0] state_dbg_o
);

  state_t state_q, state_d;
  logic   match_d;

  // Any input pattern not listed (including X/Z on bit_in) lands in S0 with no match.
  always_comb begin
    state_d = S0;
    match_d = 1'b0;
    case ({state_q, bit_in})
      {S0, 1'b0}: state_d = S0;
      {S0, 1'b1}: state_d = S1;
      {S1, 1'b0}: state_d = S0;
      {S1, 1'b1}: state_d = S2;
      {S2, 1'b0}: state_d = S3;
      {S2, 1'b1}: state_d = S2;
      {S3, 1'b0}: begin
        state_d = S0;
        match_d = 1'b1;
      end
      {S3, 1'b1}: state_d = S1;
      default:    state_d = S0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S0;
      pattern_detected <= 1'b0;
    end else begin
      state_q          <= state_d;
      pattern_detected <= match_d;
    end
  end

  assign state_dbg_o = state_q;

  a_rst_clears: assert property (@(posedge clk)
    rst |=> (state_q == S0 && !pattern_detected));

  a_s0_0: assert property (@(posedge clk) (!rst && state_q == S0 && !bit_in) |=> state_q == S0);
  a_s0_1: assert property (@(posedge clk) (!rst && state_q == S0 &&  bit_in) |=> state_q == S1);
  a_s1_0: assert property (@(posedge clk) (!rst && state_q == S1 && !bit_in) |=> state_q == S0);
  a_s1_1: assert property (@(posedge clk) (!rst && state_q == S1 &&  bit_in) |=> state_q == S2);
  a_s2_0: assert property (@(posedge clk) (!rst && state_q == S2 && !bit_in) |=> state_q == S3);
  a_s2_1: assert property (@(posedge clk) (!rst && state_q == S2 &&  bit_in) |=> state_q == S2);
  a_s3_0: assert property (@(posedge clk) (!rst && state_q == S3 && !bit_in) |=> state_q == S0);
  a_s3_1: assert property (@(posedge clk) (!rst && state_q == S3 &&  bit_in) |=> state_q == S1);

  a_pulse: assert property (@(posedge clk)
    !rst |=> pattern_detected == $past(state_q == S3 && !bit_in));

endmodule

// File: tb/tb_fsm_1100_detector.sv
// Self-checking bench for fsm_1100_detector: directed scenarios plus a random
// bit stream compared against a shift-register history model.
module tb_fsm_1100_detector;
  import fsm_1100_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_in = 1'b0;
  logic       pattern_detected;
  logic [1:0] state_dbg_o;

  int tests = 0;
  int fails = 0;

  // Reference model: history of bits sampled since the last reset.
  logic [3:0] hist = 4'b0000;
  logic [1:0] m_state = 2'd0;
  logic       m_pulse = 1'b0;
  logic       exp_q[$];

  fsm_1100_detector dut (
    .clk              (clk),
    .rst              (rst),
    .bit_in           (bit_in),
    .pattern_detected (pattern_detected),
    .state_dbg_o      (state_dbg_o)
  );

  always #5 clk = ~clk;

  // Drive one bit (and reset level) for one edge, advance the model, and
  // return #1 after the edge so outputs can be sampled.
  task automatic step(input logic b, input logic r);
    logic [3:0] nh;
    @(negedge clk);
    bit_in = b;
    rst    = r;
    @(posedge clk);
    if (r) begin
      hist    = 4'b0000;
      m_pulse = 1'b0;
      m_state = 2'd0;
    end else begin
      nh      = {hist[2:0], b};
      m_pulse = (nh == PATTERN);
      hist    = nh;
      // State = length of the longest suffix of history that is a proper prefix of 1100.
      if (hist[2:0] == 3'b110)     m_state = 2'd3;
      else if (hist[1:0] == 2'b11) m_state = 2'd2;
      else if (hist[0])            m_state = 2'd1;
      else                         m_state = 2'd0;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'($urandom_range(0, 1)), 1'b1);
      tests++;
      if (state_dbg_o !== 2'd0 || pattern_detected !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold cyc=%0d state=%0d pulse=%b expected state=0 pulse=0",
                 i, state_dbg_o, pattern_detected);
      end
    end
    step(1'b1, 1'b0);
    tests++;
    if (state_dbg_o !== 2'd1 || pattern_detected !== 1'b0) begin
      fails++;
      $display("FAIL reset_first_bit state=%0d pulse=%b expected state=1 pulse=0",
               state_dbg_o, pattern_detected);
    end
  endtask

  task automatic test_basic_match();
    logic [1:0] exp_st [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
    logic       exp_pl [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       bits   [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    step(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(bits[i], 1'b0);
      tests++;
      if (state_dbg_o !== exp_st[i] || pattern_detected !== exp_pl[i]) begin
        fails++;
        $display("FAIL basic_match idx=%0d state=%0d pulse=%b expected state=%0d pulse=%b",
                 i, state_dbg_o, pattern_detected, exp_st[i], exp_pl[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq_a = 8'b1100_1100;
    logic [5:0] seq_b = 6'b1111_00;
    int first_hit, second_hit, hits;
    step(1'b0, 1'b1);
    hits = 0; first_hit = -1; second_hit = -1;
    for (int i = 0; i < 8; i++) begin
      step(seq_a[7-i], 1'b0);
      tests++;
      if (pattern_detected !== m_pulse || state_dbg_o !== m_state) begin
        fails++;
        $display("FAIL back_to_back idx=%0d state=%0d pulse=%b expected state=%0d pulse=%b",
                 i, state_dbg_o, pattern_detected, m_state, m_pulse);
      end
      if (pattern_detected === 1'b1) begin
        hits++;
        if (first_hit < 0) first_hit = i; else second_hit = i;
      end
    end
    tests++;
    if (hits != 2 || first_hit != 3 || second_hit != 7) begin
      fails++;
      $display("FAIL back_to_back_spacing hits=%0d at %0d,%0d expected 2 at 3,7",
               hits, first_hit, second_hit);
    end

    step(1'b0, 1'b1);
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      step(seq_b[5-i], 1'b0);
      if (pattern_detected === 1'b1) hits++;
      tests++;
      if (pattern_detected !== m_pulse || state_dbg_o !== m_state) begin
        fails++;
        $display("FAIL s2_self_loop idx=%0d state=%0d pulse=%b expected state=%0d pulse=%b",
                 i, state_dbg_o, pattern_detected, m_state, m_pulse);
      end
      if (i == 3) begin
        tests++;
        if (state_dbg_o !== 2'd2) begin
          fails++;
          $display("FAIL s2_hold state=%0d expected 2", state_dbg_o);
        end
      end
    end
    tests++;
    if (hits != 1 || pattern_detected !== 1'b1) begin
      fails++;
      $display("FAIL s2_single_pulse hits=%0d last=%b expected 1 hit on final bit",
               hits, pattern_detected);
    end
  endtask

  task automatic test_near_miss();
    logic [6:0] seqs [3] = '{7'b0000100, 7'b1101100, 7'b0000110};
    int         lens [3] = '{3, 7, 4};
    int         want [3] = '{0, 1, 0};
    int hits;
    for (int s = 0; s < 3; s++) begin
      step(1'b0, 1'b1);
      hits = 0;
      for (int i = 0; i < lens[s]; i++) begin
        step(seqs[s][lens[s]-1-i], 1'b0);
        if (pattern_detected === 1'b1) hits++;
        tests++;
        if (pattern_detected !== m_pulse || state_dbg_o !== m_state) begin
          fails++;
          $display("FAIL near_miss seq=%0d idx=%0d state=%0d pulse=%b expected state=%0d pulse=%b",
                   s, i, state_dbg_o, pattern_detected, m_state, m_pulse);
        end
        if (s == 1 && i == 3) begin
          tests++;
          if (state_dbg_o !== 2'd1) begin
            fails++;
            $display("FAIL s3_one_restart state=%0d expected 1", state_dbg_o);
          end
        end
      end
      tests++;
      if (hits != want[s]) begin
        fails++;
        $display("FAIL near_miss_count seq=%0d hits=%0d expected %0d", s, hits, want[s]);
      end
    end
  endtask

  task automatic test_reset_mid_match();
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    tests++;
    if (state_dbg_o !== 2'd3) begin
      fails++;
      $display("FAIL mid_match_setup state=%0d expected 3", state_dbg_o);
    end
    step(1'b0, 1'b1);
    tests++;
    if (state_dbg_o !== 2'd0 || pattern_detected !== 1'b0) begin
      fails++;
      $display("FAIL mid_match_reset state=%0d pulse=%b expected state=0 pulse=0",
               state_dbg_o, pattern_detected);
    end
    step(1'b0, 1'b0);
    tests++;
    if (state_dbg_o !== 2'd0 || pattern_detected !== 1'b0) begin
      fails++;
      $display("FAIL mid_match_after state=%0d pulse=%b expected state=0 pulse=0",
               state_dbg_o, pattern_detected);
    end
  endtask

  task automatic test_random();
    logic exp_p;
    int   errs = 0;
    int   pulses = 0;
    step(1'b0, 1'b1);
    for (int i = 0; i < 10000; i++) begin
      // Bias toward 1s a little so 1100 appears often; rare resets exercise abort.
      step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 499) == 0));
      exp_q.push_back(m_pulse);
      exp_p = exp_q.pop_front();
      if (exp_p) pulses++;
      tests++;
      if (pattern_detected !== exp_p || state_dbg_o !== m_state) begin
        fails++;
        errs++;
        if (errs <= 10)
          $display("FAIL random idx=%0d state=%0d pulse=%b expected state=%0d pulse=%b",
                   i, state_dbg_o, pattern_detected, m_state, exp_p);
      end
    end
    tests++;
    if (pulses == 0) begin
      fails++;
      $display("FAIL random_coverage pulses=%0d expected nonzero", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_basic_match();
    test_back_to_back();
    test_near_miss();
    test_reset_mid_match();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fsm_1100_detector.md
Name: fsm_1100_detector

Overview:
- Serial bit-stream pattern detector for the sequence 1-1-0-0, first bit first.
- Samples one bit per clock on bit_in.
- Raises a registered one-cycle pulse on pattern_detected when the final 0 of the sequence has been sampled.
- Sits at the leaf of a serial-input datapath as a Moore-style registered-output FSM.

Parameters:
- None. The pattern 1100 is fixed.

Ports:
- clk  input  1  Single system clock; all state updates on its rising edge.
- rst  input  1  Reset, synchronous, active-high.
- bit_in  input  1  Serial data bit, sampled on every rising clk edge.
- pattern_detected  output  1  Registered pulse, high for exactly one cycle after a complete 1100 is sampled.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). Nothing is asynchronous.
- On a rising clk edge with rst=1:
  - state <= S0.
  - pattern_detected <= 0.
  - bit_in is ignored.
- rst held high for N cycles keeps the FSM in S0 with pattern_detected=0 throughout.
- The first bit is sampled on the first rising edge with rst=0.
- States, 2-bit encoding:
  - S0=00: idle, no useful prefix.
  - S1=01: seen "1".
  - S2=10: seen "11".
  - S3=11: seen "110".
- Transitions on each rising edge with rst=0, written as current state, bit_in -> next state:
  - S0, 1 -> S1.
  - S0, 0 -> S0.
  - S1, 1 -> S2.
  - S1, 0 -> S0.
  - S2, 1 -> S2. The last two bits are still "11".
  - S2, 0 -> S3.
  - S3, 0 -> S0. This is the match.
  - S3, 1 -> S1. The trailing "1" restarts a prefix.
- Overlap: after a match the FSM returns to S0, because no suffix of "1100" is a prefix of "1100". Overlapping detection is therefore inherently handled.
- Output:
  - pattern_detected <= (state==S3 && bit_in==0) on every non-reset edge.
  - Latency: the pulse is visible in the cycle immediately after the edge that samples the final 0.
  - The pulse is exactly 1 cycle wide.
  - Back-to-back patterns (11001100) give two pulses 4 cycles apart.
- Reset mid-sequence, including during the cycle of a match, discards the partial match and suppresses the pulse.
- X/Z on bit_in is treated as a non-matching value. The implementation must not propagate X into the state: a default branch goes to S0.
- All next-state and output logic is registered. There is no combinational path from bit_in to pattern_detected.
- Unreachable encodings, if any are added later, recover to S0.

Decomposition:
- Shared package fsm_1100_pkg holds:
  - typedef enum logic [1:0] state_t {S0, S1, S2, S3}.
  - localparam PATTERN = 4'b1100.
- No sub-module. A single always_ff holds state and pattern_detected, plus one always_comb for next state.
- Include SVA:
  - reset clears the output;
  - each transition above;
  - pattern_detected == $past(state==S3 && !bit_in) when not in reset.

Test Plan:
- Reset: rst=1 for 3 cycles with bit_in toggling -> state=S0 and pattern_detected=0 every cycle; first bit after release is sampled.
- Basic match: after reset drive 1,1,0,0 -> state S1,S2,S3,S0; pattern_detected=1 only in the cycle after the 4th bit, then 0.
- Back-to-back and overlap: drive 1,1,0,0,1,1,0,0 -> two single-cycle pulses, 4 cycles apart. Drive 1,1,1,1,0,0 -> S2 self-loops, one pulse after the final 0.
- Near misses: 1,0,0 / 1,1,0,1,1,0,0 / 0,1,1,0 -> no pulse until a full 1100. For the second sequence, exactly one pulse after its final 0; S3+1 goes to S1.
- Reset mid-match: drive 1,1,0, assert rst on the edge that samples the final 0 -> no pulse, state=S0.
- Random: 10k random bits vs a 4-bit shift-register reference model (pulse iff the last four sampled bits == 1100, with the same 1-cycle latency) -> zero mismatches.
